mdu_mac_iter: RTL and testbench

- Parametrised iterative multiply / multiply-accumulate unit for the EX stage.
- Executes MULT/MULTU/MADD/MADDU/MSUB/MSUBU over multiple cycles using a radix-2^STEP shift-add datapath.
- Uses the same start/ready level handshake as the divider, so EX holds stallreq while the result is not ready.
- Replaces the fixed two-cycle madd/msub sequencing and the single-cycle combinational multiply.

---
 rtl/mdu_mac_iter.sv | 143 ++++++++++++++
 tb/tb_mdu_mac_iter.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mdu_mac_iter.sv
// Iterative radix-2^STEP shift-add multiply / multiply-accumulate unit.
// Signed ops run on magnitudes; the sign is applied once in FIX before accumulation.
module mdu_mac_iter #(
  parameter int WIDTH = 32,
  parameter int STEP  = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic               annul_i,
  input  logic [2:0]         op_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  input  logic [WIDTH-1:0]   hi_i,
  input  logic [WIDTH-1:0]   lo_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o,
  output logic               busy_o
);

  localparam int ITERS = WIDTH / STEP;
  localparam int CNT_W = $clog2(ITERS + 1);
  localparam int DW    = 2 * WIDTH;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FIX,
    S_DONE
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;

  logic [DW-1:0]    r_mcand;
  logic [WIDTH-1:0] r_mplier;
  logic             r_neg;
  logic [DW-1:0]    r_acc;
  logic [1:0]       r_mode;
  logic [DW-1:0]    r_prod;
  logic [CNT_W-1:0] r_cnt;
  logic [DW-1:0]    r_result;
  logic             r_ready;

  logic             w_accept;
  logic             w_last;
  logic [WIDTH-1:0] w_abs1;
  logic [WIDTH-1:0] w_abs2;
  logic [DW-1:0]    w_pp;
  logic [DW-1:0]    w_p;
  logic [DW-1:0]    w_fix;

  assign w_accept = start_i & ~annul_i & ~(op_i[2] & op_i[1]);
  assign w_last   = (r_cnt == CNT_W'(ITERS - 1));

  // The most negative operand negates to itself, which read unsigned is its exact magnitude.
  assign w_abs1 = (op_i[0] && opdata1_i[WIDTH-1]) ? -opdata1_i : opdata1_i;
  assign w_abs2 = (op_i[0] && opdata2_i[WIDTH-1]) ? -opdata2_i : opdata2_i;

  // r_mcand is pre-shifted each iteration, so the digit weight is implicit.
  always_comb begin
    w_pp = '0;
    for (int j = 0; j < STEP; j++) begin
      if (r_mplier[j]) w_pp = w_pp + (r_mcand << j);
    end
  end

  assign w_p = r_neg ? -r_prod : r_prod;

  always_comb begin
    w_fix = w_p;
    case (r_mode)
      2'b01:   w_fix = r_acc + w_p;
      2'b10:   w_fix = r_acc - w_p;
      default: w_fix = w_p;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_state_nxt = S_CALC;
      S_CALC: begin
        if (annul_i)     w_state_nxt = S_IDLE;
        else if (w_last) w_state_nxt = S_FIX;
      end
      S_FIX:  w_state_nxt = annul_i ? S_IDLE : S_DONE;
      S_DONE: if (annul_i || !start_i) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mcand  <= '0;
      r_mplier <= '0;
      r_neg    <= 1'b0;
      r_acc    <= '0;
      r_mode   <= '0;
      r_prod   <= '0;
      r_cnt    <= '0;
      r_result <= '0;
      r_ready  <= 1'b0;
    end else begin
      r_ready <= (w_state_nxt == S_DONE);
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_mcand  <= DW'(w_abs1);
            r_mplier <= w_abs2;
            r_neg    <= op_i[0] & (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
            r_acc    <= {hi_i, lo_i};
            r_mode   <= op_i[2:1];
            r_prod   <= '0;
            r_cnt    <= '0;
          end
        end
        S_CALC: begin
          if (!annul_i) begin
            r_prod   <= r_prod + w_pp;
            r_mcand  <= r_mcand << STEP;
            r_mplier <= r_mplier >> STEP;
            r_cnt    <= r_cnt + CNT_W'(1);
          end
        end
        S_FIX: begin
          if (!annul_i) r_result <= w_fix;
        end
        default: ;
      endcase
    end
  end

  assign result_o = r_result;
  assign ready_o  = r_ready;
  assign busy_o   = (r_state == S_CALC) || (r_state == S_FIX);

endmodule

// File: tb/tb_mdu_mac_iter.sv
// Bench for mdu_mac_iter: one 32/2 instance plus 16-bit instances with STEP 1, 4 and 8,
// checked against a plain two's-complement arithmetic model.
module tb_mdu_mac_iter;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        start_v [4];
  logic        annul_v [4];
  logic [2:0]  op_v    [4];
  logic [31:0] a_v     [4];
  logic [31:0] b_v     [4];
  logic [31:0] hi_v    [4];
  logic [31:0] lo_v    [4];
  logic [63:0] res_v   [4];
  logic        rdy_v   [4];
  logic        busy_v  [4];
  logic [63:0] last_exp [4];

  int WV [4] = '{32, 16, 16, 16};
  int SV [4] = '{2, 1, 4, 8};

  int n_vec = 0;
  int n_err = 0;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    localparam int W = (g == 0) ? 32 : 16;
    localparam int S = (g == 0) ? 2 : (g == 1) ? 1 : (g == 2) ? 4 : 8;
    logic [2*W-1:0] w_res;
    mdu_mac_iter #(.WIDTH(W), .STEP(S)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .start_i   (start_v[g]),
      .annul_i   (annul_v[g]),
      .op_i      (op_v[g]),
      .opdata1_i (a_v[g][W-1:0]),
      .opdata2_i (b_v[g][W-1:0]),
      .hi_i      (hi_v[g][W-1:0]),
      .lo_i      (lo_v[g][W-1:0]),
      .result_o  (w_res),
      .ready_o   (rdy_v[g]),
      .busy_o    (busy_v[g])
    );
    assign res_v[g] = 64'(w_res);
  end

  function automatic logic [63:0] ref_model(input int w, input logic [2:0] op,
                                            input logic [31:0] a, input logic [31:0] b,
                                            input logic [31:0] hi, input logic [31:0] lo);
    logic [63:0] ea, eb, p, acc, r, mask;
    ea = {32'd0, a};
    eb = {32'd0, b};
    if (op[0]) begin
      if (a[w-1]) ea = ea | (64'hFFFF_FFFF_FFFF_FFFF << w);
      if (b[w-1]) eb = eb | (64'hFFFF_FFFF_FFFF_FFFF << w);
    end
    p   = ea * eb;
    acc = ({32'd0, hi} << w) | {32'd0, lo};
    case (op[2:1])
      2'd1:    r = acc + p;
      2'd2:    r = acc - p;
      default: r = p;
    endcase
    mask = (w == 32) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (2 * w)) - 64'd1);
    return r & mask;
  endfunction

  function automatic logic [31:0] rnd(input int w);
    logic [31:0] m, r;
    m = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    case ($urandom_range(0, 5))
      0:       r = 32'd0;
      1:       r = m;
      2:       r = 32'd1 << (w - 1);
      3:       r = 32'd1;
      default: r = $urandom;
    endcase
    return r & m;
  endfunction

  // Starts at a negedge with the unit idle; returns at a negedge with it idle again.
  task automatic run_op(input int k, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] hi, input logic [31:0] lo,
                        input int hold, output logic [63:0] r);
    int lat, nbusy, n, bad;
    logic [63:0] exp_r;
    n     = WV[k] / SV[k];
    exp_r = ref_model(WV[k], op, a, b, hi, lo);
    start_v[k] = 1'b1; op_v[k] = op; a_v[k] = a; b_v[k] = b; hi_v[k] = hi; lo_v[k] = lo;
    lat = 0; nbusy = 0;
    @(negedge clk); lat++;
    if (busy_v[k]) nbusy++;
    op_v[k] = 3'($urandom_range(0, 7));
    a_v[k] = rnd(WV[k]); b_v[k] = rnd(WV[k]); hi_v[k] = rnd(WV[k]); lo_v[k] = rnd(WV[k]);
    while (!rdy_v[k] && lat < 300) begin
      @(negedge clk); lat++;
      if (busy_v[k]) nbusy++;
    end
    r = res_v[k];
    n_vec++;
    if (lat !== n + 2) begin
      n_err++;
      $display("FAIL latency inst%0d op=%0d: got %0d cycles, expected %0d", k, op, lat, n + 2);
    end
    n_vec++;
    if (nbusy !== n + 1) begin
      n_err++;
      $display("FAIL busy_len inst%0d op=%0d: got %0d cycles, expected %0d", k, op, nbusy, n + 1);
    end
    n_vec++;
    if (r !== exp_r) begin
      n_err++;
      $display("FAIL result inst%0d op=%0d a=%h b=%h hi=%h lo=%h: got %h expected %h",
               k, op, a, b, hi, lo, r, exp_r);
    end
    bad = 0;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (rdy_v[k] !== 1'b1 || busy_v[k] !== 1'b0 || res_v[k] !== exp_r) bad++;
    end
    if (hold > 0) begin
      n_vec++;
      if (bad !== 0) begin
        n_err++;
        $display("FAIL done_stable inst%0d: %0d unstable cycles, expected 0", k, bad);
      end
    end
    start_v[k] = 1'b0;
    @(negedge clk);
    n_vec++;
    if (rdy_v[k] !== 1'b0 || res_v[k] !== exp_r) begin
      n_err++;
      $display("FAIL release inst%0d: ready=%b res=%h, expected ready=0 res=%h",
               k, rdy_v[k], res_v[k], exp_r);
    end
    last_exp[k] = exp_r;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int k = 0; k < 4; k++) begin
      start_v[k] = 1'b1; annul_v[k] = 1'b0; op_v[k] = 3'd0;
      a_v[k] = 32'd3; b_v[k] = 32'd5; hi_v[k] = '0; lo_v[k] = '0;
    end
    repeat (3) @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      n_vec++;
      if (res_v[k] !== 64'd0 || rdy_v[k] !== 1'b0 || busy_v[k] !== 1'b0) begin
        n_err++;
        $display("FAIL reset inst%0d: res=%h ready=%b busy=%b, expected all 0",
                 k, res_v[k], rdy_v[k], busy_v[k]);
      end
      start_v[k] = 1'b0;
      last_exp[k] = 64'd0;
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_directed();
    logic [2:0]  op [5]  = '{3'b001, 3'b000, 3'b001, 3'b011, 3'b100};
    logic [31:0] a  [5]  = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'h8000_0000, 32'd4, 32'd1};
    logic [31:0] b  [5]  = '{32'd5, 32'hFFFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFE, 32'd1};
    logic [31:0] lo [5]  = '{32'd0, 32'd0, 32'd0, 32'h10, 32'd0};
    logic [63:0] ex [5]  = '{64'hFFFF_FFFF_FFFF_FFF1, 64'hFFFF_FFFE_0000_0001,
                             64'h4000_0000_0000_0000, 64'h0000_0000_0000_0008,
                             64'hFFFF_FFFF_FFFF_FFFF};
    logic [63:0] r;
    for (int i = 0; i < 5; i++) begin
      run_op(0, op[i], a[i], b[i], 32'd0, lo[i], 1, r);
      n_vec++;
      if (r !== ex[i]) begin
        n_err++;
        $display("FAIL directed%0d: got %h expected %h", i, r, ex[i]);
      end
    end
  endtask

  task automatic test_reserved();
    int bad;
    for (int v = 6; v < 8; v++) begin
      bad = 0;
      start_v[0] = 1'b1; op_v[0] = 3'(v); a_v[0] = 32'd9; b_v[0] = 32'd9;
      repeat (6) begin
        @(negedge clk);
        if (busy_v[0] !== 1'b0 || rdy_v[0] !== 1'b0 || res_v[0] !== last_exp[0]) bad++;
      end
      start_v[0] = 1'b0;
      n_vec++;
      if (bad !== 0) begin
        n_err++;
        $display("FAIL reserved op=%0d: %0d active cycles, expected 0", v, bad);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_annul();
    int bad;
    logic [63:0] r;
    // Annul during CALC, cycle 5.
    start_v[0] = 1'b1; op_v[0] = 3'b010; a_v[0] = rnd(32); b_v[0] = rnd(32);
    hi_v[0] = rnd(32); lo_v[0] = rnd(32);
    repeat (5) @(negedge clk);
    annul_v[0] = 1'b1; start_v[0] = 1'b0;
    @(negedge clk);
    annul_v[0] = 1'b0;
    n_vec++;
    if (busy_v[0] !== 1'b0 || rdy_v[0] !== 1'b0 || res_v[0] !== last_exp[0]) begin
      n_err++;
      $display("FAIL annul_calc: busy=%b ready=%b res=%h, expected 0 0 %h",
               busy_v[0], rdy_v[0], res_v[0], last_exp[0]);
    end
    bad = 0;
    repeat (25) begin
      @(negedge clk);
      if (rdy_v[0] !== 1'b0 || res_v[0] !== last_exp[0]) bad++;
    end
    n_vec++;
    if (bad !== 0) begin
      n_err++;
      $display("FAIL annul_quiet: %0d cycles with ready/result change, expected 0", bad);
    end
    // Annul while in FIX (cycle N+1).
    start_v[0] = 1'b1; op_v[0] = 3'b001; a_v[0] = rnd(32); b_v[0] = rnd(32);
    repeat (17) @(negedge clk);
    annul_v[0] = 1'b1; start_v[0] = 1'b0;
    @(negedge clk);
    annul_v[0] = 1'b0;
    n_vec++;
    if (busy_v[0] !== 1'b0 || rdy_v[0] !== 1'b0 || res_v[0] !== last_exp[0]) begin
      n_err++;
      $display("FAIL annul_fix: busy=%b ready=%b res=%h, expected 0 0 %h",
               busy_v[0], rdy_v[0], res_v[0], last_exp[0]);
    end
    // Annul in IDLE blocks acceptance.
    start_v[0] = 1'b1; annul_v[0] = 1'b1; op_v[0] = 3'b000;
    bad = 0;
    repeat (4) begin
      @(negedge clk);
      if (busy_v[0] !== 1'b0) bad++;
    end
    start_v[0] = 1'b0; annul_v[0] = 1'b0;
    n_vec++;
    if (bad !== 0) begin
      n_err++;
      $display("FAIL annul_idle: %0d busy cycles, expected 0", bad);
    end
    @(negedge clk);
    // Annul in DONE while start is still held.
    run_op(0, 3'b011, rnd(32), rnd(32), rnd(32), rnd(32), 0, r);
    start_v[0] = 1'b1; op_v[0] = 3'b000; a_v[0] = 32'd2; b_v[0] = 32'd3;
    repeat (19) @(negedge clk);
    n_vec++;
    if (rdy_v[0] !== 1'b1 || res_v[0] !== 64'd6) begin
      n_err++;
      $display("FAIL pre_annul_done: ready=%b res=%h, expected 1 %h", rdy_v[0], res_v[0], 64'd6);
    end
    annul_v[0] = 1'b1;
    @(negedge clk);
    annul_v[0] = 1'b0; start_v[0] = 1'b0;
    n_vec++;
    if (rdy_v[0] !== 1'b0 || busy_v[0] !== 1'b0 || res_v[0] !== 64'd6) begin
      n_err++;
      $display("FAIL annul_done: ready=%b busy=%b res=%h, expected 0 0 %h",
               rdy_v[0], busy_v[0], res_v[0], 64'd6);
    end
    last_exp[0] = 64'd6;
    @(negedge clk);
  endtask

  task automatic test_rst_mid();
    logic [63:0] r;
    start_v[0] = 1'b1; op_v[0] = 3'b000; a_v[0] = rnd(32) | 32'd1; b_v[0] = rnd(32) | 32'd1;
    repeat (9) @(negedge clk);
    rst = 1'b1; start_v[0] = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    n_vec++;
    if (res_v[0] !== 64'd0 || rdy_v[0] !== 1'b0 || busy_v[0] !== 1'b0) begin
      n_err++;
      $display("FAIL rst_mid: res=%h ready=%b busy=%b, expected all 0",
               res_v[0], rdy_v[0], busy_v[0]);
    end
    for (int k = 0; k < 4; k++) last_exp[k] = 64'd0;
    @(negedge clk);
    run_op(0, 3'b000, 32'd7, 32'd6, 32'd0, 32'd0, 0, r);
    n_vec++;
    if (r !== 64'h2A) begin
      n_err++;
      $display("FAIL post_rst_multu: got %h expected %h", r, 64'h2A);
    end
  endtask

  task automatic test_random(input int k, input int count);
    logic [63:0] r;
    for (int i = 0; i < count; i++) begin
      run_op(k, 3'($urandom_range(0, 5)), rnd(WV[k]), rnd(WV[k]), rnd(WV[k]), rnd(WV[k]),
             $urandom_range(0, 3), r);
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_directed();
    test_reserved();
    test_annul();
    test_rst_mid();
    test_random(0, 150);
    test_random(1, 250);
    test_random(2, 250);
    test_random(3, 250);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
